// File: rtl/uart_rx_frame_if.sv
// Receive-side bus of uart_rx_frame: serial line and frame-slot inputs, memory-write and status outputs.
// Latency: none; this file only bundles wires.
// Backpressure: none; the frame consumer throttles only through ack after full.
// Ports (slave = receiver, master = line driver / frame consumer):
//   rx, cycle[5:0], ack                                   master -> slave
//   addr[8:0], data[7:0], we, full, frame_err, byte_cnt[4:0]  slave -> master
interface uart_rx_frame_if;
    logic       rx;
    logic [5:0] cycle;
    logic       ack;
    logic [8:0] addr;
    logic [7:0] data;
    logic       we;
    logic       full;
    logic       frame_err;
    logic [4:0] byte_cnt;

    modport master (
        output rx, cycle, ack,
        input  addr, data, we, full, frame_err, byte_cnt
    );

    modport slave (
        input  rx, cycle, ack,
        output addr, data, we, full, frame_err, byte_cnt
    );
endinterface

// File: rtl/uart_rx_frame.sv
// RS485 8N1 UART receiver: oversamples rx and writes each byte to frame memory at byte_cnt + cycle*4.
// Latency: we rises 2 + OVS/2 + 9*OVS + 1 clks after the rx falling edge (+/-1 clk synchroniser phase).
// Backpressure: after BYTES bytes, full holds and incoming bytes are dropped until ack.
// Ports: clk (baud*OVS), reset (sync, active-high), bus (uart_rx_frame_if.slave).
// Optional feature: define RX_TIMEOUT_EN to discard a partial frame after TIMEOUT idle clks.
module uart_rx_frame #(
    parameter logic [4:0] BYTES   = 5'd4,
    parameter int         OVS     = 8,
    parameter int         TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    uart_rx_frame_if.slave    bus
);

    localparam int CNT_W = $clog2(OVS);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVS / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVS - 1);

    if ((OVS < 4) || (OVS % 2 != 0) || (BYTES == 5'd0) || (TIMEOUT < 1)) begin : g_bad_params
        $error("uart_rx_frame: illegal parameter combination");
    end

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, STORE, DONE} state_t;

    state_t           state_q, state_d;
    logic             rx_meta_q, rxs_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [8:0]       addr_q, addr_d;
    logic [7:0]       data_q, data_d;
    logic             we_q, we_d;
    logic             full_q, full_d;
    logic             ferr_q, ferr_d;
    logic [4:0]       byte_cnt_q, byte_cnt_d;

`ifdef RX_TIMEOUT_EN
    localparam int GAP_W = $clog2(TIMEOUT + 1);
    logic [GAP_W-1:0] gap_q, gap_d;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        addr_d     = addr_q;
        data_d     = data_q;
        we_d       = 1'b0;
        full_d     = full_q;
        ferr_d     = 1'b0;
        byte_cnt_d = byte_cnt_q;

        case (state_q)
            IDLE: begin
                if (!rxs_q) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                // Half a bit in: the line must still be low, else it was a glitch.
                if (cnt_q == CNT_HALF) begin
                    if (rxs_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        cnt_d   = '0;
                        bit_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rxs_q, shift_q[7:1]};
                    bit_d   = bit_q + 4'd1;
                    if (bit_q == 4'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rxs_q) begin
                        // Outputs are registered so we/addr/data are valid together during STORE.
                        state_d = STORE;
                        we_d    = 1'b1;
                        data_d  = shift_q;
                        addr_d  = {4'd0, byte_cnt_q} + {1'b0, bus.cycle, 2'b00};
                    end else begin
                        state_d = IDLE;
                        ferr_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STORE: begin
                byte_cnt_d = byte_cnt_q + 5'd1;
                if (byte_cnt_q + 5'd1 == BYTES) begin
                    state_d = DONE;
                    full_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            DONE: begin
                if (bus.ack) begin
                    state_d    = IDLE;
                    full_d     = 1'b0;
                    byte_cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef RX_TIMEOUT_EN
        // Gap only runs while idling inside a partial frame; leaving IDLE clears it.
        gap_d = '0;
        if ((state_q == IDLE) && (state_d == IDLE) && (byte_cnt_q != 5'd0)) begin
            if (gap_q == GAP_W'(TIMEOUT - 1)) begin
                byte_cnt_d = '0;
                ferr_d     = 1'b1;
            end else begin
                gap_d = gap_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q  <= 1'b1;
            rxs_q      <= 1'b1;
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            we_q       <= 1'b0;
            full_q     <= 1'b0;
            ferr_q     <= 1'b0;
            byte_cnt_q <= '0;
`ifdef RX_TIMEOUT_EN
            gap_q      <= '0;
`endif
        end else begin
            rx_meta_q  <= bus.rx;
            rxs_q      <= rx_meta_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            we_q       <= we_d;
            full_q     <= full_d;
            ferr_q     <= ferr_d;
            byte_cnt_q <= byte_cnt_d;
`ifdef RX_TIMEOUT_EN
            gap_q      <= gap_d;
`endif
        end
    end

    assign bus.addr      = addr_q;
    assign bus.data      = data_q;
    assign bus.we        = we_q;
    assign bus.full      = full_q;
    assign bus.frame_err = ferr_q;
    assign bus.byte_cnt  = byte_cnt_q;

endmodule
